// File: rtl/nblsu_lsq_ooo_if.sv
// Dcache request/response channel between the load/store queue and the data cache.
// master = queue side, slave = dcache side.
interface nblsu_lsq_ooo_if #(
    parameter int unsigned XLEN             = 64,
    parameter int unsigned VIRTUAL_ADDR_LEN = 39,
    parameter int unsigned LSQ_IDX_W        = 3
);
    logic                        req_valid_o;
    logic                        req_ready_i;
    logic                        req_opcode_o;
    logic                        req_sign_o;
    logic [1:0]                  req_size_o;
    logic [VIRTUAL_ADDR_LEN-1:0] req_addr_o;
    logic [XLEN-1:0]             req_data_o;
    logic [LSQ_IDX_W-1:0]        req_lsq_index_o;
    logic                        resp_valid_i;
    logic [LSQ_IDX_W-1:0]        resp_lsq_index_i;
    logic [XLEN-1:0]             resp_data_i;
    logic                        resp_ready_o;

    modport master (
        output req_valid_o, req_opcode_o, req_sign_o, req_size_o, req_addr_o, req_data_o,
               req_lsq_index_o, resp_ready_o,
        input  req_ready_i, resp_valid_i, resp_lsq_index_i, resp_data_i
    );

    modport slave (
        input  req_valid_o, req_opcode_o, req_sign_o, req_size_o, req_addr_o, req_data_o,
               req_lsq_index_o, resp_ready_o,
        output req_ready_i, resp_valid_i, resp_lsq_index_i, resp_data_i
    );
endinterface

// File: rtl/nblsu_lsq_ooo.sv
// Multi-entry load/store queue: in-order issue to dcache, out-of-order responses by queue index,
// in-order retire to ROB/PRF, and a drain phase that swallows stale responses after a flush.
module nblsu_lsq_ooo #(
    parameter int unsigned XLEN                 = 64,
    parameter int unsigned VIRTUAL_ADDR_LEN     = 39,
    parameter int unsigned PHY_REG_ADDR_WIDTH   = 6,
    parameter int unsigned ROB_INDEX_WIDTH      = 4,
    parameter int unsigned EXCEPTION_CODE_WIDTH = 4,
    parameter int unsigned LSQ_DEPTH            = 8,
    localparam int unsigned LSQ_IDX_W           = $clog2(LSQ_DEPTH)
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            flush,
    input  logic                            valid_i,
    output logic                            lsu_ready_o,
    input  logic [VIRTUAL_ADDR_LEN-1:0]     address_i,
    input  logic [XLEN-1:0]                 rs2_data_i,
    input  logic                            opcode_i,
    input  logic [1:0]                      size_i,
    input  logic                            load_sign_i,
    input  logic [PHY_REG_ADDR_WIDTH-1:0]   rd_addr_i,
    input  logic [ROB_INDEX_WIDTH-1:0]      rob_index_i,
    input  logic                            exception_valid_i,
    input  logic [EXCEPTION_CODE_WIDTH-1:0] ecause_i,
    nblsu_lsq_ooo_if.master                 dc,
    output logic                            ls_done_o,
    output logic [ROB_INDEX_WIDTH-1:0]      rob_index_o,
    output logic                            load_data_valid_o,
    output logic [XLEN-1:0]                 load_data_o,
    output logic [PHY_REG_ADDR_WIDTH-1:0]   rd_addr_o,
    output logic                            exception_valid_o,
    output logic [EXCEPTION_CODE_WIDTH-1:0] ecause_o
);

    typedef enum logic [1:0] {StEmpty, StWaitIssue, StIssued, StDone} state_e;
    typedef logic [LSQ_IDX_W-1:0] idx_t;
    typedef logic [LSQ_IDX_W:0]   cnt_t;

    localparam idx_t IdxOne  = idx_t'(1);
    localparam cnt_t CntFull = cnt_t'(LSQ_DEPTH);

    state_e state_q [LSQ_DEPTH];
    state_e state_d [LSQ_DEPTH];

    logic                            opcode_q [LSQ_DEPTH];
    logic                            sign_q   [LSQ_DEPTH];
    logic [1:0]                      size_q   [LSQ_DEPTH];
    logic [VIRTUAL_ADDR_LEN-1:0]     addr_q   [LSQ_DEPTH];
    logic [XLEN-1:0]                 data_q   [LSQ_DEPTH];
    logic [PHY_REG_ADDR_WIDTH-1:0]   rd_q     [LSQ_DEPTH];
    logic [ROB_INDEX_WIDTH-1:0]      rob_q    [LSQ_DEPTH];
    logic                            exc_q    [LSQ_DEPTH];
    logic [EXCEPTION_CODE_WIDTH-1:0] ecause_q [LSQ_DEPTH];

    idx_t head_q, head_d, issue_q, issue_d, tail_q, tail_d;
    cnt_t count_q, count_d, pend_q, pend_d, outst_q, outst_d;
    logic drain_q, drain_d;

    logic enq, issue_hs, skip, resp_hit, retire;

    assign lsu_ready_o = (count_q != CntFull) && !drain_q;
    assign enq         = valid_i && lsu_ready_o && !flush;

    assign dc.req_valid_o     = (state_q[issue_q] == StWaitIssue) && !drain_q && !flush;
    assign dc.req_lsq_index_o = issue_q;
    assign dc.req_opcode_o    = dc.req_valid_o & opcode_q[issue_q];
    assign dc.req_sign_o      = dc.req_valid_o & sign_q[issue_q];
    assign dc.req_size_o      = dc.req_valid_o ? size_q[issue_q] : '0;
    assign dc.req_addr_o      = dc.req_valid_o ? addr_q[issue_q] : '0;
    assign dc.req_data_o      = dc.req_valid_o ? data_q[issue_q] : '0;
    assign dc.resp_ready_o    = 1'b1;

    assign issue_hs = dc.req_valid_o && dc.req_ready_i;
    // pend_q counts entries between issue_q and tail_q, so a full wrap is not mistaken for empty
    assign skip     = (state_q[issue_q] == StDone) && (pend_q != '0) && !flush && !drain_q;
    assign resp_hit = dc.resp_valid_i && !drain_q && !flush &&
                      (state_q[dc.resp_lsq_index_i] == StIssued);

    assign retire            = (state_q[head_q] == StDone) && !flush && !drain_q;
    assign ls_done_o         = retire;
    assign load_data_valid_o = retire && !opcode_q[head_q] && !exc_q[head_q];
    assign exception_valid_o = retire && exc_q[head_q];
    assign rob_index_o       = retire ? rob_q[head_q] : '0;
    assign load_data_o       = load_data_valid_o ? data_q[head_q] : '0;
    assign rd_addr_o         = load_data_valid_o ? rd_q[head_q] : '0;
    assign ecause_o          = exception_valid_o ? ecause_q[head_q] : '0;

    always_comb begin
        for (int i = 0; i < LSQ_DEPTH; i++) begin
            state_d[i] = state_q[i];
        end
        if (flush) begin
            for (int i = 0; i < LSQ_DEPTH; i++) begin
                state_d[i] = StEmpty;
            end
        end else begin
            if (retire)   state_d[head_q] = StEmpty;
            if (issue_hs) state_d[issue_q] = StIssued;
            if (resp_hit) state_d[dc.resp_lsq_index_i] = StDone;
            if (enq)      state_d[tail_q] = exception_valid_i ? StDone : StWaitIssue;
        end
    end

    always_comb begin
        outst_d = outst_q + cnt_t'(issue_hs);
        if (dc.resp_valid_i && (outst_d != '0)) begin
            outst_d = outst_d - cnt_t'(1);
        end
        drain_d = (flush || drain_q) && (outst_d != '0);
        if (flush) begin
            head_d  = '0;
            issue_d = '0;
            tail_d  = '0;
            count_d = '0;
            pend_d  = '0;
        end else begin
            head_d  = retire ? head_q + IdxOne : head_q;
            issue_d = (issue_hs || skip) ? issue_q + IdxOne : issue_q;
            tail_d  = enq ? tail_q + IdxOne : tail_q;
            count_d = count_q + cnt_t'(enq) - cnt_t'(retire);
            pend_d  = pend_q + cnt_t'(enq) - cnt_t'(issue_hs || skip);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < LSQ_DEPTH; i++) begin
                state_q[i] <= StEmpty;
            end
            head_q  <= '0;
            issue_q <= '0;
            tail_q  <= '0;
            count_q <= '0;
            pend_q  <= '0;
            outst_q <= '0;
            drain_q <= 1'b0;
        end else begin
            for (int i = 0; i < LSQ_DEPTH; i++) begin
                state_q[i] <= state_d[i];
            end
            head_q  <= head_d;
            issue_q <= issue_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            pend_q  <= pend_d;
            outst_q <= outst_d;
            drain_q <= drain_d;
        end
    end

    // Payload is only observed through state-qualified paths, so it needs no reset.
    always_ff @(posedge clk) begin
        if (enq) begin
            opcode_q[tail_q] <= opcode_i;
            sign_q[tail_q]   <= load_sign_i;
            size_q[tail_q]   <= size_i;
            addr_q[tail_q]   <= address_i;
            data_q[tail_q]   <= rs2_data_i;
            rd_q[tail_q]     <= rd_addr_i;
            rob_q[tail_q]    <= rob_index_i;
            exc_q[tail_q]    <= exception_valid_i;
            ecause_q[tail_q] <= ecause_i;
        end
        if (resp_hit) begin
            data_q[dc.resp_lsq_index_i] <= dc.resp_data_i;
        end
    end

    resp_to_issued_entry: assert property (@(posedge clk) disable iff (!rstn)
        (dc.resp_valid_i && !drain_q && !flush) |-> (state_q[dc.resp_lsq_index_i] == StIssued));

endmodule

// File: tb/tb_nblsu_lsq_ooo.sv
// Directed self-checking bench for nblsu_lsq_ooo: one task per scenario, hand-computed expectations.
module tb_nblsu_lsq_ooo;
    localparam int unsigned XLEN = 64;
    localparam int unsigned VA   = 39;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        flush, valid_i, opcode_i, load_sign_i, exception_valid_i;
    logic [VA-1:0]   address_i;
    logic [XLEN-1:0] rs2_data_i;
    logic [1:0]  size_i;
    logic [5:0]  rd_addr_i;
    logic [3:0]  rob_index_i, ecause_i;
    logic        lsu_ready_o, ls_done_o, load_data_valid_o, exception_valid_o;
    logic [3:0]  rob_index_o, ecause_o;
    logic [XLEN-1:0] load_data_o;
    logic [5:0]  rd_addr_o;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    nblsu_lsq_ooo_if #(.XLEN(XLEN), .VIRTUAL_ADDR_LEN(VA), .LSQ_IDX_W(3)) dc ();

    nblsu_lsq_ooo dut (
        .clk(clk), .rstn(rstn), .flush(flush), .valid_i(valid_i), .lsu_ready_o(lsu_ready_o),
        .address_i(address_i), .rs2_data_i(rs2_data_i), .opcode_i(opcode_i), .size_i(size_i),
        .load_sign_i(load_sign_i), .rd_addr_i(rd_addr_i), .rob_index_i(rob_index_i),
        .exception_valid_i(exception_valid_i), .ecause_i(ecause_i), .dc(dc),
        .ls_done_o(ls_done_o), .rob_index_o(rob_index_o), .load_data_valid_o(load_data_valid_o),
        .load_data_o(load_data_o), .rd_addr_o(rd_addr_o), .exception_valid_o(exception_valid_o),
        .ecause_o(ecause_o)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        flush = 0; valid_i = 0; opcode_i = 0; load_sign_i = 0; exception_valid_i = 0;
        address_i = '0; rs2_data_i = '0; size_i = 2'd3; rd_addr_i = '0; rob_index_i = '0;
        ecause_i = '0; dc.resp_valid_i = 0; dc.resp_lsq_index_i = '0; dc.resp_data_i = '0;
    endtask

    task automatic do_reset();
        idle();
        dc.req_ready_i = 0;
        rstn = 0;
        #3;
        rstn = 1;
        cyc();
    endtask

    task automatic enq(input logic op, input logic [VA-1:0] a, input logic [XLEN-1:0] d,
                       input logic [3:0] rob, input logic [5:0] rd, input logic exc,
                       input logic [3:0] ec);
        valid_i = 1; opcode_i = op; address_i = a; rs2_data_i = d; rob_index_i = rob;
        rd_addr_i = rd; exception_valid_i = exc; ecause_i = ec;
    endtask

    task automatic resp(input logic v, input logic [2:0] idx, input logic [XLEN-1:0] d);
        dc.resp_valid_i = v; dc.resp_lsq_index_i = idx; dc.resp_data_i = d;
    endtask

    task automatic test_reset();
        idle();
        dc.req_ready_i = 0;
        rstn = 0;
        #2;
        checks++; if ({lsu_ready_o, dc.resp_ready_o} !== 2'b11) begin errs++;
            $display("FAIL reset_ready: got %b want 11", {lsu_ready_o, dc.resp_ready_o}); end
        checks++; if ({dc.req_valid_o, ls_done_o, load_data_valid_o, exception_valid_o} !== 4'b0)
            begin errs++; $display("FAIL reset_valids: got %b want 0000",
            {dc.req_valid_o, ls_done_o, load_data_valid_o, exception_valid_o}); end
        checks++; if ({rob_index_o, load_data_o, rd_addr_o, ecause_o} !== '0) begin errs++;
            $display("FAIL reset_fields: got nonzero want 0"); end
        #1 rstn = 1;
        cyc();
    endtask

    task automatic test_single_load();
        do_reset();
        dc.req_ready_i = 1;
        enq(0, 39'h1000, 0, 4'd1, 6'd5, 0, 0);
        #1;
        checks++; if (dc.req_valid_o !== 1'b0) begin errs++;
            $display("FAIL single_same_cycle_req: got %b want 0", dc.req_valid_o); end
        cyc(); idle(); #1;
        checks++; if ({dc.req_valid_o, dc.req_lsq_index_o, dc.req_addr_o} !== {1'b1, 3'd0, 39'h1000})
            begin errs++; $display("FAIL single_req: got %b/%0d/%0h want 1/0/1000",
            dc.req_valid_o, dc.req_lsq_index_o, dc.req_addr_o); end
        cyc();
        resp(1, 3'd0, 64'h55); #1;
        checks++; if ({dc.req_valid_o, ls_done_o} !== 2'b00) begin errs++;
            $display("FAIL single_resp_cycle: got %b want 00", {dc.req_valid_o, ls_done_o}); end
        cyc(); idle(); #1;
        checks++; if ({ls_done_o, load_data_valid_o, exception_valid_o} !== 3'b110) begin errs++;
            $display("FAIL single_done: got %b want 110",
            {ls_done_o, load_data_valid_o, exception_valid_o}); end
        checks++; if ({load_data_o, rob_index_o, rd_addr_o} !== {64'h55, 4'd1, 6'd5}) begin errs++;
            $display("FAIL single_fields: got %0h/%0d/%0d want 55/1/5",
            load_data_o, rob_index_o, rd_addr_o); end
        cyc();
        checks++; if ({ls_done_o, load_data_o} !== '0) begin errs++;
            $display("FAIL single_after: got %b/%0h want 0/0", ls_done_o, load_data_o); end
    endtask

    task automatic test_out_of_order();
        do_reset();
        dc.req_ready_i = 1;
        for (int k = 0; k < 4; k++) begin
            if (k < 3) enq(0, 39'h100 + 39'(k * 8), 0, 4'(3 + k), 6'(10 + k), 0, 0);
            else idle();
            #1;
            if (k > 0) begin
                checks++; if ({dc.req_valid_o, dc.req_lsq_index_o} !== {1'b1, 3'(k - 1)}) begin
                    errs++; $display("FAIL ooo_issue%0d: got %b/%0d want 1/%0d", k,
                    dc.req_valid_o, dc.req_lsq_index_o, k - 1); end
            end
            cyc();
        end
        resp(1, 3'd2, 64'h22); #1;
        checks++; if (ls_done_o !== 1'b0) begin errs++;
            $display("FAIL ooo_hold2: got %b want 0", ls_done_o); end
        cyc();
        resp(1, 3'd0, 64'h20); #1;
        checks++; if (ls_done_o !== 1'b0) begin errs++;
            $display("FAIL ooo_hold0: got %b want 0", ls_done_o); end
        cyc();
        resp(1, 3'd1, 64'h21); #1;
        checks++; if ({ls_done_o, rob_index_o, load_data_o} !== {1'b1, 4'd3, 64'h20}) begin errs++;
            $display("FAIL ooo_retire0: got %b/%0d/%0h want 1/3/20",
            ls_done_o, rob_index_o, load_data_o); end
        cyc(); idle(); #1;
        checks++; if ({ls_done_o, rob_index_o, load_data_o} !== {1'b1, 4'd4, 64'h21}) begin errs++;
            $display("FAIL ooo_retire1: got %b/%0d/%0h want 1/4/21",
            ls_done_o, rob_index_o, load_data_o); end
        cyc();
        checks++; if ({ls_done_o, rob_index_o, load_data_o} !== {1'b1, 4'd5, 64'h22}) begin errs++;
            $display("FAIL ooo_retire2: got %b/%0d/%0h want 1/5/22",
            ls_done_o, rob_index_o, load_data_o); end
        cyc();
        checks++; if (ls_done_o !== 1'b0) begin errs++;
            $display("FAIL ooo_empty: got %b want 0", ls_done_o); end
    endtask

    task automatic test_full_wrap();
        do_reset();
        for (int k = 0; k < 8; k++) begin
            enq(0, 39'(k), 0, 4'(k), 6'(k), 0, 0); #1;
            checks++; if (lsu_ready_o !== 1'b1) begin errs++;
                $display("FAIL full_ready%0d: got %b want 1", k, lsu_ready_o); end
            cyc();
        end
        enq(0, 39'h90, 0, 4'd9, 6'd9, 0, 0);
        dc.req_ready_i = 1; #1;
        checks++; if ({lsu_ready_o, dc.req_valid_o, dc.req_lsq_index_o} !== {2'b01, 3'd0}) begin
            errs++; $display("FAIL full_not_ready: got %b/%b/%0d want 0/1/0",
            lsu_ready_o, dc.req_valid_o, dc.req_lsq_index_o); end
        cyc();
        dc.req_ready_i = 0; resp(1, 3'd0, 64'h77); #1;
        checks++; if ({lsu_ready_o, ls_done_o} !== 2'b00) begin errs++;
            $display("FAIL full_resp: got %b want 00", {lsu_ready_o, ls_done_o}); end
        cyc(); resp(0, 3'd0, 0); #1;
        checks++; if ({ls_done_o, rob_index_o, lsu_ready_o} !== {1'b1, 4'd0, 1'b0}) begin errs++;
            $display("FAIL full_retire_no_bypass: got %b/%0d/%b want 1/0/0",
            ls_done_o, rob_index_o, lsu_ready_o); end
        cyc();
        checks++; if (lsu_ready_o !== 1'b1) begin errs++;
            $display("FAIL full_ready_after_retire: got %b want 1", lsu_ready_o); end
        cyc(); idle(); #1;
        checks++; if (lsu_ready_o !== 1'b0) begin errs++;
            $display("FAIL full_refill: got %b want 0", lsu_ready_o); end
        dc.req_ready_i = 1;
        for (int k = 1; k <= 8; k++) begin
            checks++; if ({dc.req_valid_o, dc.req_lsq_index_o} !== {1'b1, 3'(k % 8)}) begin
                errs++; $display("FAIL full_issue%0d: got %b/%0d want 1/%0d", k,
                dc.req_valid_o, dc.req_lsq_index_o, k % 8); end
            if (k == 8) begin
                checks++; if (dc.req_addr_o !== 39'h90) begin errs++;
                    $display("FAIL full_wrap_addr: got %0h want 90", dc.req_addr_o); end
            end
            cyc();
        end
        dc.req_ready_i = 0;
    endtask

    task automatic test_fault_bypass();
        do_reset();
        dc.req_ready_i = 1;
        enq(1, 39'h2000, 64'hdead, 4'd6, 6'd0, 0, 0);
        cyc();
        enq(0, 39'h2008, 0, 4'd7, 6'd8, 1, 4'd4); #1;
        checks++; if ({dc.req_valid_o, dc.req_lsq_index_o, dc.req_opcode_o, dc.req_data_o} !==
            {1'b1, 3'd0, 1'b1, 64'hdead}) begin errs++;
            $display("FAIL fault_store_req: got %b/%0d/%b/%0h want 1/0/1/dead", dc.req_valid_o,
            dc.req_lsq_index_o, dc.req_opcode_o, dc.req_data_o); end
        cyc();
        enq(0, 39'h3000, 0, 4'd8, 6'd9, 0, 0); #1;
        checks++; if (dc.req_valid_o !== 1'b0) begin errs++;
            $display("FAIL fault_skip: got %b want 0", dc.req_valid_o); end
        cyc(); idle(); #1;
        checks++; if ({dc.req_valid_o, dc.req_lsq_index_o, dc.req_addr_o} !==
            {1'b1, 3'd2, 39'h3000}) begin errs++;
            $display("FAIL fault_next_req: got %b/%0d/%0h want 1/2/3000",
            dc.req_valid_o, dc.req_lsq_index_o, dc.req_addr_o); end
        cyc();
        resp(1, 3'd0, 0); #1;
        checks++; if (ls_done_o !== 1'b0) begin errs++;
            $display("FAIL fault_wait: got %b want 0", ls_done_o); end
        cyc();
        resp(1, 3'd2, 64'h99); #1;
        checks++; if ({ls_done_o, rob_index_o, load_data_valid_o, exception_valid_o} !==
            {1'b1, 4'd6, 2'b00}) begin errs++;
            $display("FAIL fault_store_retire: got %b/%0d/%b/%b want 1/6/0/0", ls_done_o,
            rob_index_o, load_data_valid_o, exception_valid_o); end
        cyc(); idle(); #1;
        checks++; if ({ls_done_o, rob_index_o, load_data_valid_o, exception_valid_o, ecause_o} !==
            {1'b1, 4'd7, 2'b01, 4'd4}) begin errs++;
            $display("FAIL fault_exc_retire: got %b/%0d/%b/%b/%0d want 1/7/0/1/4", ls_done_o,
            rob_index_o, load_data_valid_o, exception_valid_o, ecause_o); end
        cyc();
        checks++; if ({load_data_valid_o, rob_index_o, load_data_o, rd_addr_o} !==
            {1'b1, 4'd8, 64'h99, 6'd9}) begin errs++;
            $display("FAIL fault_load_retire: got %b/%0d/%0h/%0d want 1/8/99/9",
            load_data_valid_o, rob_index_o, load_data_o, rd_addr_o); end
        cyc();
        checks++; if (ls_done_o !== 1'b0) begin errs++;
            $display("FAIL fault_empty: got %b want 0", ls_done_o); end
    endtask

    task automatic test_flush_drain();
        do_reset();
        dc.req_ready_i = 1;
        enq(0, 39'h40, 0, 4'd1, 6'd1, 0, 0);
        cyc();
        enq(0, 39'h48, 0, 4'd2, 6'd2, 0, 0);
        cyc(); idle(); #1;
        checks++; if ({dc.req_valid_o, dc.req_lsq_index_o} !== {1'b1, 3'd1}) begin errs++;
            $display("FAIL flush_issue1: got %b/%0d want 1/1", dc.req_valid_o, dc.req_lsq_index_o);
        end
        cyc();
        flush = 1; #1;
        checks++; if ({dc.req_valid_o, ls_done_o} !== 2'b00) begin errs++;
            $display("FAIL flush_cycle: got %b want 00", {dc.req_valid_o, ls_done_o}); end
        cyc(); flush = 0;
        resp(1, 3'd0, 64'haa); #1;
        checks++; if ({lsu_ready_o, ls_done_o} !== 2'b00) begin errs++;
            $display("FAIL flush_drain1: got %b want 00", {lsu_ready_o, ls_done_o}); end
        cyc();
        resp(1, 3'd1, 64'hbb); #1;
        checks++; if ({lsu_ready_o, ls_done_o} !== 2'b00) begin errs++;
            $display("FAIL flush_drain2: got %b want 00", {lsu_ready_o, ls_done_o}); end
        cyc(); idle();
        enq(0, 39'h50, 0, 4'd3, 6'd3, 0, 0); #1;
        checks++; if ({lsu_ready_o, ls_done_o} !== 2'b10) begin errs++;
            $display("FAIL flush_ready_again: got %b want 10", {lsu_ready_o, ls_done_o}); end
        cyc(); idle(); #1;
        checks++; if ({dc.req_valid_o, dc.req_lsq_index_o, dc.req_addr_o} !==
            {1'b1, 3'd0, 39'h50}) begin errs++;
            $display("FAIL flush_restart: got %b/%0d/%0h want 1/0/50",
            dc.req_valid_o, dc.req_lsq_index_o, dc.req_addr_o); end
        cyc();
    endtask

    task automatic test_async_reset();
        do_reset();
        dc.req_ready_i = 1;
        enq(0, 39'h60, 0, 4'd1, 6'd1, 0, 0);
        cyc();
        enq(0, 39'h68, 0, 4'd2, 6'd2, 0, 0);
        cyc(); idle(); dc.req_ready_i = 0; #1;
        checks++; if ({dc.req_valid_o, dc.req_lsq_index_o} !== {1'b1, 3'd1}) begin errs++;
            $display("FAIL areset_pre: got %b/%0d want 1/1", dc.req_valid_o, dc.req_lsq_index_o);
        end
        rstn = 0; #1;
        checks++; if ({dc.req_valid_o, ls_done_o, lsu_ready_o, dc.resp_ready_o} !== 4'b0011) begin
            errs++; $display("FAIL areset_outputs: got %b want 0011",
            {dc.req_valid_o, ls_done_o, lsu_ready_o, dc.resp_ready_o}); end
        checks++; if ({dc.req_lsq_index_o, dc.req_addr_o} !== '0) begin errs++;
            $display("FAIL areset_req_fields: got %0d/%0h want 0/0",
            dc.req_lsq_index_o, dc.req_addr_o); end
        #2 rstn = 1;
        cyc();
        dc.req_ready_i = 1;
        enq(0, 39'h70, 0, 4'd5, 6'd5, 0, 0);
        cyc(); idle(); #1;
        checks++; if ({dc.req_valid_o, dc.req_lsq_index_o, dc.req_addr_o} !==
            {1'b1, 3'd0, 39'h70}) begin errs++;
            $display("FAIL areset_pointers: got %b/%0d/%0h want 1/0/70",
            dc.req_valid_o, dc.req_lsq_index_o, dc.req_addr_o); end
        cyc();
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_out_of_order();
        test_full_wrap();
        test_fault_bypass();
        test_flush_drain();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
